// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the sprite DMA sequencer and the CPU/bus fabric.
// master = DMA side (snoops CPU, drives the bus), slave = system side.
interface oam_dma_controller_if #(
  parameter int P_addr_width = 16,
  parameter int P_data_width = 8
);
  logic                    I_cpu_write;
  logic [P_addr_width-1:0] I_cpu_addr;
  logic [P_data_width-1:0] I_cpu_data;
  logic                    I_halted;
  logic [P_data_width-1:0] I_bus_data;
  logic                    O_halt;
  logic                    O_bus_own;
  logic [P_addr_width-1:0] O_addr;
  logic [P_data_width-1:0] O_data;
  logic                    O_read;
  logic                    O_write;
  logic                    O_busy;
  logic                    O_done;

  modport master (
    input  I_cpu_write, I_cpu_addr, I_cpu_data, I_halted, I_bus_data,
    output O_halt, O_bus_own, O_addr, O_data, O_read, O_write, O_busy, O_done
  );

  modport slave (
    output I_cpu_write, I_cpu_addr, I_cpu_data, I_halted, I_bus_data,
    input  O_halt, O_bus_own, O_addr, O_data, O_read, O_write, O_busy, O_done
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite DMA: snoops the trigger write, halts the CPU, copies one page into OAM.
// 513/514 owned cycles per transfer; waits indefinitely on the CPU halt acknowledge.
module oam_dma_controller #(
  parameter int                    P_addr_width    = 16,
  parameter int                    P_data_width    = 8,
  parameter logic [P_addr_width-1:0] P_trigger_addr  = 16'h4014,
  parameter logic [P_addr_width-1:0] P_oam_port_addr = 16'h2004,
  parameter int                    P_length        = 256
) (
  input logic                   I_clock,
  input logic                   I_reset,
  oam_dma_controller_if.master  bus
);
  localparam int P_count_width = (P_length > 1) ? $clog2(P_length) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HALT, ST_DUMMY, ST_ALIGN, ST_READ, ST_WRITE
  } state_t;

  state_t                   state_q, state_d;
  logic [P_data_width-1:0]  page_q;
  logic [P_count_width-1:0] count_q;
  logic [P_data_width-1:0]  byte_q;
  logic                     parity_q;

  logic                    trigger;
  logic                    last_byte;
  logic [P_addr_width-1:0] rd_addr;

  logic                    halt, bus_own, rd, wr, busy, done;
  logic [P_addr_width-1:0] addr;
  logic [P_data_width-1:0] data;

  assign trigger   = (state_q == ST_IDLE) && bus.I_cpu_write && (bus.I_cpu_addr == P_trigger_addr);
  assign last_byte = (count_q == P_count_width'(P_length - 1));
  assign rd_addr   = P_addr_width'({page_q, 8'(count_q)});

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      page_q   <= '0;
      count_q  <= '0;
      byte_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (trigger) begin
        page_q  <= bus.I_cpu_data;
        count_q <= '0;
      end
      if (state_q == ST_READ)  byte_q  <= bus.I_bus_data;
      if (state_q == ST_WRITE) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    halt    = 1'b0;
    bus_own = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    addr    = '0;
    data    = '0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = ST_HALT;
      end
      ST_HALT: begin
        halt = 1'b1;
        busy = 1'b1;
        if (bus.I_halted) state_d = ST_DUMMY;
      end
      ST_DUMMY: begin
        halt    = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        // Reads must sit on parity 0; next cycle's parity is the inverse of now.
        state_d = parity_q ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        halt    = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        halt    = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        rd      = 1'b1;
        addr    = rd_addr;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        halt    = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        wr      = 1'b1;
        addr    = P_oam_port_addr;
        data    = byte_q;
        if (last_byte) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.O_halt    = halt;
  assign bus.O_bus_own = bus_own;
  assign bus.O_addr    = addr;
  assign bus.O_data    = data;
  assign bus.O_read    = rd;
  assign bus.O_write   = wr;
  assign bus.O_busy    = busy;
  assign bus.O_done    = done;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: memory model returns addr[7:0]^A5, scoreboard
// holds the expected read/write sequence per transfer.
module tb_oam_dma_controller;
  logic I_clock = 1'b0;
  logic I_reset;
  logic tb_par;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   owned_cnt, done_cnt, first_rd_own;
  bit   rd_seen;

  oam_dma_controller_if #(.P_addr_width(16), .P_data_width(8)) bus ();

  oam_dma_controller dut (
    .I_clock (I_clock),
    .I_reset (I_reset),
    .bus     (bus.master)
  );

  always #5 I_clock = ~I_clock;

  assign bus.I_bus_data = bus.O_read ? (bus.O_addr[7:0] ^ 8'hA5) : 8'h00;

  // Independent cycle-parity reference: 0 in the first cycle after reset.
  always @(posedge I_clock) tb_par <= I_reset ? 1'b0 : ~tb_par;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge I_clock) begin
    if (bus.O_read && !rd_seen) begin
      rd_seen      = 1'b1;
      first_rd_own = owned_cnt;
    end
    if (bus.O_read || bus.O_write) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_kind", {31'd0, bus.O_write}, {31'd0, mon_e.wr});
        check("sb_addr", {16'd0, bus.O_addr}, {16'd0, mon_e.addr});
        if (mon_e.wr) check("sb_wdata", {24'd0, bus.O_data}, {24'd0, mon_e.data});
      end
    end else begin
      check("idle_bus", {8'd0, bus.O_addr, bus.O_data}, 0);
    end
    check("busy_eq_halt", {31'd0, bus.O_busy}, {31'd0, bus.O_halt});
    if (bus.O_bus_own) owned_cnt++;
    if (bus.O_done) done_cnt++;
  end

  task automatic step();
    @(posedge I_clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_halt"}, {31'd0, bus.O_halt}, 0);
    check({tag, "_own"},  {31'd0, bus.O_bus_own}, 0);
    check({tag, "_busy"}, {31'd0, bus.O_busy}, 0);
    check({tag, "_strb"}, {30'd0, bus.O_read, bus.O_write}, 0);
    check({tag, "_done"}, {31'd0, bus.O_done}, 0);
  endtask

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: {page, 8'(i)}, data: 8'h00});
      exp_q.push_back('{wr: 1'b1, addr: 16'h2004, data: 8'(i) ^ 8'hA5});
    end
  endtask

  // Trigger lands so that DUMMY parity gives (want_align ? ALIGN : direct READ).
  task automatic start_xfer(input logic [7:0] page, input bit want_align, input int ack_dly);
    logic pt;
    pt = want_align ? 1'(ack_dly & 1) : ~1'(ack_dly & 1);
    step();
    while (tb_par != pt) step();
    push_page(page);
    owned_cnt = 0;
    done_cnt  = 0;
    rd_seen   = 1'b0;
    bus.I_cpu_write = 1'b1;
    bus.I_cpu_addr  = 16'h4014;
    bus.I_cpu_data  = page;
    step();
    bus.I_cpu_write = 1'b0;
    bus.I_cpu_addr  = 16'h0000;
    bus.I_cpu_data  = 8'h00;
    @(negedge I_clock);
    #1;
    check("halt_rise", {31'd0, bus.O_halt}, 1);
    for (int k = 0; k < ack_dly; k++) begin
      if (k > 0) begin
        @(negedge I_clock);
        #1;
      end
      check("wait_own",  {31'd0, bus.O_bus_own}, 0);
      check("wait_strb", {30'd0, bus.O_read, bus.O_write}, 0);
      check("wait_halt", {31'd0, bus.O_halt}, 1);
      step();
    end
    bus.I_halted = 1'b1;
  endtask

  task automatic finish_xfer(input bit want_align);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 700) begin
      @(negedge I_clock);
      #1;
      if (bus.O_done) got = 1'b1;
      n++;
    end
    check("done_seen", {31'd0, got}, 1);
    if (got) begin
      check("done_wr",   {31'd0, bus.O_write}, 1);
      check("done_addr", {16'd0, bus.O_addr}, 32'h2004);
    end
    step();
    bus.I_halted = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge I_clock);
      #1;
      check_quiet("post");
    end
    check("owned_cycles", owned_cnt, want_align ? 514 : 513);
    check("done_pulses",  done_cnt, 1);
    check("first_rd_pos", first_rd_own, want_align ? 2 : 1);
    check("sb_drained",   exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    owned_cnt    = 0;
    done_cnt     = 0;
    first_rd_own = 0;
    rd_seen      = 1'b0;
    I_reset         = 1'b1;
    bus.I_cpu_write = 1'b1;
    bus.I_cpu_addr  = 16'h4014;
    bus.I_cpu_data  = 8'h09;
    bus.I_halted    = 1'b0;
    repeat (2) step();
    I_reset         = 1'b0;
    bus.I_cpu_write = 1'b0;
    bus.I_cpu_addr  = 16'h0000;
    bus.I_cpu_data  = 8'h00;
    @(negedge I_clock);
    #1;
    check_quiet("rst0");
    check("rst0_bus", {8'd0, bus.O_addr, bus.O_data}, 0);

    // Mid-idle reset pulse
    repeat (3) step();
    I_reset = 1'b1;
    repeat (2) step();
    I_reset = 1'b0;
    @(negedge I_clock);
    #1;
    check_quiet("rst1");

    // Foreign writes while idle must not start a transfer
    step();
    bus.I_cpu_write = 1'b1;
    bus.I_cpu_addr  = 16'h4015;
    bus.I_cpu_data  = 8'h07;
    repeat (3) step();
    bus.I_cpu_write = 1'b0;
    bus.I_cpu_addr  = 16'h0000;
    bus.I_cpu_data  = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge I_clock);
      #1;
      check_quiet("foreign");
    end

    // Even parity: no ALIGN
    start_xfer(8'h02, 1'b0, 1);
    finish_xfer(1'b0);

    // Odd parity: one ALIGN
    start_xfer(8'h02, 1'b1, 1);
    finish_xfer(1'b1);

    // Delayed ack, plus retrigger and I_halted drop mid-transfer
    start_xfer(8'h02, 1'b0, 5);
    repeat (40) step();
    bus.I_cpu_write = 1'b1;
    bus.I_cpu_addr  = 16'h4014;
    bus.I_cpu_data  = 8'h07;
    step();
    bus.I_cpu_write = 1'b0;
    bus.I_cpu_addr  = 16'h0000;
    bus.I_cpu_data  = 8'h00;
    bus.I_halted    = 1'b0;
    repeat (10) step();
    bus.I_halted    = 1'b1;
    finish_xfer(1'b0);

    // Reset during the WRITE of byte 0x40
    start_xfer(8'h02, 1'b0, 1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge I_clock);
      #1;
      if (bus.O_write && bus.O_data == (8'h40 ^ 8'hA5)) got = 1'b1;
      n++;
    end
    check("wr40_seen", {31'd0, got}, 1);
    I_reset = 1'b1;
    step();
    I_reset      = 1'b0;
    bus.I_halted = 1'b0;
    exp_q.delete();
    @(negedge I_clock);
    #1;
    check_quiet("rst_mid");
    check("rst_mid_bus", {8'd0, bus.O_addr, bus.O_data}, 0);
    @(negedge I_clock);
    #1;
    check_quiet("rst_mid_idle");

    start_xfer(8'h03, 1'b1, 2);
    finish_xfer(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sprite DMA sequencer for the 2A03 core. It snoops CPU writes to the DMA trigger address and latches the written byte as a source page. It then halts the CPU and takes over the bus to copy P_length bytes from page:00 upward into the PPU OAM data port. Read/write slots alternate on the cycle-parity grid, so a transfer takes 513 or 514 CPU cycles after the halt is acknowledged.

Parameters:
P_addr_width, 16, bus address width
P_data_width, 8, bus data width
P_trigger_addr, 16'h4014, CPU write address that starts a transfer
P_oam_port_addr, 16'h2004, destination address for every DMA write
P_length, 256, bytes per transfer (power of two, at most 256)

Ports:
I_clock  input  1  system clock; one CPU cycle per rising edge
I_reset  input  1  synchronous, active-high reset
I_cpu_write  input  1  CPU bus write strobe (snooped)
I_cpu_addr  input  P_addr_width  CPU bus address (snooped)
I_cpu_data  input  P_data_width  CPU bus write data (snooped)
I_halted  input  1  CPU acknowledges halt and has released the bus
I_bus_data  input  P_data_width  read data returned by the bus for O_read cycles
O_halt  output  1  halt request to CPU
O_bus_own  output  1  DMA drives the bus this cycle
O_addr  output  P_addr_width  DMA bus address
O_data  output  P_data_width  DMA write data
O_read  output  1  DMA read strobe
O_write  output  1  DMA write strobe
O_busy  output  1  transfer in progress (any state except IDLE)
O_done  output  1  one-cycle pulse on the final write cycle

Behaviour:
- Reset: all outputs 0; state IDLE; page, count, byte latch and parity cleared. Reset overrides every other input on the same edge.
- Parity flop: toggles every clock and is 0 after reset. Parity 0 is a "get" (read) slot; parity 1 is a "put" (write) slot.
- IDLE: trigger is I_cpu_write=1 and I_cpu_addr==P_trigger_addr at a rising edge.
  - On trigger: page<=I_cpu_data, count<=0, go to HALT.
  - O_halt rises on the cycle after the trigger write.
- HALT: O_halt=1, O_busy=1, bus not owned. Waits with no timeout until I_halted=1 is sampled, then goes to DUMMY.
- DUMMY: one cycle with O_bus_own=1 and no strobes.
  - Next state is READ if the next cycle's parity is 0, otherwise ALIGN.
- ALIGN: one idle owned cycle, then READ (READ always lands on parity 0).
- READ: O_read=1, O_addr={page, count[7:0]}. The byte latch captures I_bus_data at the end of the cycle. Next state is WRITE.
- WRITE: O_write=1, O_addr=P_oam_port_addr, O_data=latched byte.
  - count<=count+1.
  - If count==P_length-1: O_done=1 this cycle, next state IDLE; O_halt and O_bus_own drop the following cycle.
  - Otherwise next state READ.
- O_halt stays 1 and O_busy stays 1 from HALT through the final WRITE inclusive. O_bus_own=1 in DUMMY, ALIGN, READ and WRITE.
- Triggers seen in any state other than IDLE are ignored; page is not re-latched.
- I_halted dropping mid-transfer is ignored; only the HALT state samples it.
- Count width is log2(P_length). The wrap at the last byte terminates the transfer; no cross-page addressing.
- Inactive output values: O_addr and O_data are 0 when their strobe is low.
- Cycle total from the first owned cycle: 1 + (0|1) + 2*P_length.

Test Plan:
- Reset check: assert I_reset for 2 cycles mid-idle -> all outputs 0 and O_busy=0 on the following cycle.
- Even-parity transfer: CPU writes 8'h02 to 16'h4014; I_halted=1 one cycle after O_halt rises; DUMMY lands so that READ parity is 0 with no ALIGN; memory model returns addr[7:0]^8'hA5 -> 256 reads at 16'h0200..16'h02FF; 256 writes to 16'h2004 with matching data; 513 owned cycles; a single O_done pulse.
- Odd-parity transfer: same as above with the trigger shifted by one cycle -> exactly one ALIGN cycle; 514 owned cycles; identical data sequence.
- Delayed halt ack: I_halted held 0 for 5 cycles after O_halt rises -> no O_bus_own and no strobes during the wait; transfer then proceeds normally.
- Retrigger and foreign writes: a write of 8'h07 to 16'h4014 during the transfer, and writes to 16'h4015 while idle -> page stays 8'h02; no extra transfer starts.
- Reset mid-transfer: assert I_reset during the WRITE of byte 8'h40 -> next cycle all outputs 0 and state IDLE; a fresh trigger with page 8'h03 then runs a full 16'h0300..16'h03FF transfer.
